// File: rtl/seg_ripple_adder.sv
// Multi-cycle segmented ripple-carry adder/subtractor: SEG bits per clock with a registered carry.
// Optional saturation of the result on signed overflow when SEG_RIPPLE_ADDER_SAT_EN is defined.
module seg_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pos_ovf,
  output logic             neg_ovf,
  output logic             dbg_state_o
);

  // WIDTH must be >= 2 and a multiple of SEG.
  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG-1:0]   seg_sum;
  logic             carry_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] s_d;
  logic             pos_d;
  logic             neg_d;
  logic             last_seg;

  // Handshake: start is accepted on a rising edge only while busy=0; done
  // pulses for one cycle with s/cout/flags valid, and those outputs hold
  // until the next completion.
  always_comb begin
    seg_a              = a_q[idx_q*SEG +: SEG];
    seg_b              = b_q[idx_q*SEG +: SEG];
    {carry_d, seg_sum} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_q};
    r_d                = r_q;
    r_d[idx_q*SEG +: SEG] = seg_sum;
    last_seg           = (idx_q == LAST_IDX);
    // B is already inverted for subtraction, so one rule covers both modes.
    pos_d = ~a_q[WIDTH-1] & ~b_q[WIDTH-1] &  r_d[WIDTH-1];
    neg_d =  a_q[WIDTH-1] &  b_q[WIDTH-1] & ~r_d[WIDTH-1];
    s_d   = r_d;
`ifdef SEG_RIPPLE_ADDER_SAT_EN
    if (pos_d) begin
      s_d = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (neg_d) begin
      s_d = {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      pos_ovf <= 1'b0;
      neg_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          r_q     <= r_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (last_seg) begin
            s       <= s_d;
            cout    <= carry_d;
            pos_ovf <= pos_d;
            neg_ovf <= neg_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_ripple_adder.sv
// Directed bench for seg_ripple_adder (32/8) plus a 16-bit model regression for SEG = 1, 4, 16.
module tb_seg_ripple_adder;

`ifdef SEG_RIPPLE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        cout;
  logic        pos_ovf;
  logic        neg_ovf;
  logic        dbg_state;

  logic        r_start [3];
  logic        r_sub   [3];
  logic        r_cin   [3];
  logic [15:0] r_a     [3];
  logic [15:0] r_b     [3];
  logic        r_busy  [3];
  logic        r_done  [3];
  logic [15:0] r_s     [3];
  logic        r_cout  [3];
  logic        r_pos   [3];
  logic        r_neg   [3];
  logic        r_state [3];

  int checks = 0;
  int errors = 0;

  seg_ripple_adder #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .pos_ovf(pos_ovf), .neg_ovf(neg_ovf),
    .dbg_state_o(dbg_state)
  );

  seg_ripple_adder #(.WIDTH(16), .SEG(1)) u_w16_s1 (
    .clk(clk), .rst_n(rst_n), .start(r_start[0]), .sub(r_sub[0]), .a(r_a[0]), .b(r_b[0]),
    .cin(r_cin[0]), .busy(r_busy[0]), .done(r_done[0]), .s(r_s[0]), .cout(r_cout[0]),
    .pos_ovf(r_pos[0]), .neg_ovf(r_neg[0]), .dbg_state_o(r_state[0])
  );

  seg_ripple_adder #(.WIDTH(16), .SEG(4)) u_w16_s4 (
    .clk(clk), .rst_n(rst_n), .start(r_start[1]), .sub(r_sub[1]), .a(r_a[1]), .b(r_b[1]),
    .cin(r_cin[1]), .busy(r_busy[1]), .done(r_done[1]), .s(r_s[1]), .cout(r_cout[1]),
    .pos_ovf(r_pos[1]), .neg_ovf(r_neg[1]), .dbg_state_o(r_state[1])
  );

  seg_ripple_adder #(.WIDTH(16), .SEG(16)) u_w16_s16 (
    .clk(clk), .rst_n(rst_n), .start(r_start[2]), .sub(r_sub[2]), .a(r_a[2]), .b(r_b[2]),
    .cin(r_cin[2]), .busy(r_busy[2]), .done(r_done[2]), .s(r_s[2]), .cout(r_cout[2]),
    .pos_ovf(r_pos[2]), .neg_ovf(r_neg[2]), .dbg_state_o(r_state[2])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input logic tcin);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 3; i++) begin
      r_start[i] = 1'b0; r_sub[i] = 1'b0; r_cin[i] = 1'b0; r_a[i] = '0; r_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, cout, pos_ovf, neg_ovf} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {busy, done, cout, pos_ovf, neg_ovf}); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s: got %h exp 00000000", s); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b exp 0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b exp 00", {busy, done}); end
  endtask

  task automatic test_carry();
    int busy_cnt;
    int lat;
    bit s_leak;
    busy_cnt = 0; lat = 0; s_leak = 1'b0;
    start_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (s !== 32'h0) s_leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency: got %0d exp 4", lat); end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL carry_busy_cycles: got %0d exp 4", busy_cnt); end
    checks++; if (s_leak !== 1'b0) begin errors++; $display("FAIL carry_s_hidden: got %b exp 0", s_leak); end
    checks++; if (s !== 32'h00010000) begin errors++; $display("FAIL carry_s: got %h exp 00010000", s); end
    checks++; if ({cout, pos_ovf, neg_ovf, busy} !== 4'b0000) begin errors++; $display("FAIL carry_flags: got %b exp 0000", {cout, pos_ovf, neg_ovf, busy}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL carry_done_pulse: got %b exp 0", done); end
    checks++; if (s !== 32'h00010000) begin errors++; $display("FAIL carry_s_hold: got %h exp 00010000", s); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] exp_s;
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done(lat);
    exp_s = SAT ? 32'h7FFFFFFF : 32'h80000000;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pos_done: got %b exp 1", done); end
    checks++; if (s !== exp_s) begin errors++; $display("FAIL pos_s: got %h exp %h", s, exp_s); end
    checks++; if ({cout, pos_ovf, neg_ovf} !== 3'b010) begin errors++; $display("FAIL pos_flags: got %b exp 010", {cout, pos_ovf, neg_ovf}); end
    start_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    wait_done(lat);
    exp_s = SAT ? 32'h80000000 : 32'h00000000;
    checks++; if (s !== exp_s) begin errors++; $display("FAIL neg_s: got %h exp %h", s, exp_s); end
    checks++; if ({cout, pos_ovf, neg_ovf} !== 3'b101) begin errors++; $display("FAIL neg_flags: got %b exp 101", {cout, pos_ovf, neg_ovf}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(lat);
    checks++; if (s !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub1_s: got %h exp fffffffe", s); end
    checks++; if ({cout, pos_ovf, neg_ovf} !== 3'b000) begin errors++; $display("FAIL sub1_flags: got %b exp 000", {cout, pos_ovf, neg_ovf}); end
    start_op(32'd7, 32'd5, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b exp 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d exp 4", lat); end
    checks++; if (s !== 32'd2) begin errors++; $display("FAIL sub2_s: got %h exp 00000002", s); end
    checks++; if ({cout, pos_ovf, neg_ovf} !== 3'b100) begin errors++; $display("FAIL sub2_flags: got %b exp 100", {cout, pos_ovf, neg_ovf}); end
  endtask

  task automatic test_ignore_start();
    int lat;
    start_op(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat + 2 !== 4) begin errors++; $display("FAIL ignore_latency: got %0d exp 4", lat + 2); end
    checks++; if (s !== 32'h00000030) begin errors++; $display("FAIL ignore_s: got %h exp 00000030", s); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue: got %b exp 00", {busy, done}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw_done;
    saw_done = 1'b0;
    start_op(32'h00000001, 32'h00000002, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cout, pos_ovf, neg_ovf, dbg_state} !== 6'b0) begin errors++; $display("FAIL midrst_ctrl: got %b exp 000000", {busy, done, cout, pos_ovf, neg_ovf, dbg_state}); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL midrst_s: got %h exp 00000000", s); end
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b exp 0", saw_done); end
    start_op(32'h00000100, 32'h00000023, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d exp 4", lat); end
    checks++; if (s !== 32'h00000123) begin errors++; $display("FAIL midrst_s_after: got %h exp 00000123", s); end
  endtask

  task automatic test_random_w16();
    int          nseg [3];
    int          lat;
    logic [15:0] bb;
    logic [16:0] sum;
    logic [15:0] es;
    logic        ci;
    logic        ep;
    logic        en;
    nseg[0] = 16; nseg[1] = 4; nseg[2] = 1;
    for (int inst = 0; inst < 3; inst++) begin
      for (int n = 0; n < 20; n++) begin
        r_a[inst] = 16'($urandom); r_b[inst] = 16'($urandom);
        r_sub[inst] = (n % 4 == 3); r_cin[inst] = 1'($urandom_range(0, 1));
        bb = r_sub[inst] ? ~r_b[inst] : r_b[inst];
        ci = r_sub[inst] ? 1'b1 : r_cin[inst];
        sum = {1'b0, r_a[inst]} + {1'b0, bb} + {16'b0, ci};
        es = sum[15:0];
        ep = ~r_a[inst][15] & ~bb[15] &  es[15];
        en =  r_a[inst][15] &  bb[15] & ~es[15];
        if (SAT && ep) es = 16'h7FFF;
        if (SAT && en) es = 16'h8000;
        r_start[inst] = 1'b1;
        @(posedge clk); #1;
        r_start[inst] = 1'b0;
        r_a[inst] = 16'($urandom); r_b[inst] = 16'($urandom);
        lat = 0;
        while (!r_done[inst] && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        checks++; if (lat !== nseg[inst]) begin errors++; $display("FAIL rand%0d_latency: got %0d exp %0d", inst, lat, nseg[inst]); end
        checks++; if (r_s[inst] !== es) begin errors++; $display("FAIL rand%0d_s: got %h exp %h", inst, r_s[inst], es); end
        checks++; if ({r_cout[inst], r_pos[inst], r_neg[inst]} !== {sum[16], ep, en}) begin errors++; $display("FAIL rand%0d_flags: got %b exp %b", inst, {r_cout[inst], r_pos[inst], r_neg[inst]}, {sum[16], ep, en}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
